// File: rtl/lb_frame_sequencer.sv
// Frame sequencer for the 3x3 line-buffer window generator.
// Gates camera pixels into the line buffer, appends one flush line after the
// last camera line, counts returned windows to tag each one with its centre
// coordinate, and reports frame completion and protocol errors.
module lb_frame_sequencer #(
    parameter int                    H_PIXEL     = 640,
    parameter int                    V_PIXEL     = 480,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] FLUSH_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cam_vsync,
    input  logic                  cam_de,
    input  logic [DATA_WIDTH-1:0] cam_data,
    output logic                  lb_vsync,
    output logic                  lb_valid,
    output logic [DATA_WIDTH-1:0] lb_data,
    input  logic                  window_valid,
    output logic                  cen_valid,
    output logic [9:0]            cen_x,
    output logic [9:0]            cen_y,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err
);

    localparam logic [9:0] X_LAST  = 10'(H_PIXEL - 1);
    localparam logic [9:0] Y_LAST  = 10'(V_PIXEL - 1);
    // window rows run one past the image because of the flush line
    localparam logic [9:0] WY_LAST = 10'(V_PIXEL);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t     state;
    logic       vsync_d;
    logic [9:0] in_x;
    logic [9:0] in_y;
    logic [9:0] wx;
    logic [9:0] wy;
    logic [9:0] fcnt;

    logic vs_edge;
    logic last_win;

    assign vs_edge  = cam_vsync && !vsync_d;
    assign last_win = window_valid && (wx == X_LAST) && (wy == WY_LAST);

    // Frame state, pixel gating, flush generation and window counting.
    // A vsync edge overrides everything else in its cycle; a pixel arriving
    // with it becomes pixel (0,0) of the new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vsync_d    <= 1'b0;
            in_x       <= '0;
            in_y       <= '0;
            wx         <= '0;
            wy         <= '0;
            fcnt       <= '0;
            lb_vsync   <= 1'b0;
            lb_valid   <= 1'b0;
            lb_data    <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            vsync_d    <= cam_vsync;
            lb_vsync   <= cam_vsync;
            lb_valid   <= 1'b0;
            frame_done <= 1'b0;

            if (vs_edge) begin
                if (state != IDLE)
                    err <= 1'b1;
                state <= ACTIVE;
                fcnt  <= '0;
                wx    <= '0;
                wy    <= '0;
                in_y  <= '0;
                if (cam_de) begin
                    lb_valid <= 1'b1;
                    lb_data  <= cam_data;
                    in_x     <= 10'd1;
                end else begin
                    in_x     <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (cam_de)
                            err <= 1'b1;
                    end
                    ACTIVE: begin
                        if (cam_de) begin
                            lb_valid <= 1'b1;
                            lb_data  <= cam_data;
                            if (in_x == X_LAST) begin
                                in_x <= '0;
                                if (in_y == Y_LAST) begin
                                    in_y  <= '0;
                                    fcnt  <= '0;
                                    state <= FLUSH;
                                end else begin
                                    in_y <= in_y + 10'd1;
                                end
                            end else begin
                                in_x <= in_x + 10'd1;
                            end
                        end
                    end
                    FLUSH: begin
                        // one synthetic line, back-to-back, camera locked out
                        lb_valid <= 1'b1;
                        lb_data  <= FLUSH_VALUE;
                        if (cam_de)
                            err <= 1'b1;
                        if (fcnt == X_LAST) begin
                            fcnt  <= '0;
                            state <= DRAIN;
                        end else begin
                            fcnt <= fcnt + 10'd1;
                        end
                    end
                    DRAIN: begin
                        if (cam_de)
                            err <= 1'b1;
                        if (last_win)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase

                // window beat counting; beats outside a frame are errors
                if (window_valid) begin
                    if (state == IDLE) begin
                        err <= 1'b1;
                    end else begin
                        if (wx == X_LAST) begin
                            wx <= '0;
                            wy <= (wy == WY_LAST) ? 10'd0 : wy + 10'd1;
                        end else begin
                            wx <= wx + 10'd1;
                        end
                        if (last_win)
                            frame_done <= 1'b1;
                    end
                end
            end
        end
    end

    // Centre tag: window (wx,wy) is centred one column left and one row up.
    always_comb begin
        cen_valid = window_valid && (wx != 10'd0) && (wy != 10'd0);
        cen_x     = cen_valid ? (wx - 10'd1) : 10'd0;
        cen_y     = cen_valid ? (wy - 10'd1) : 10'd0;
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_lb_frame_sequencer.sv
// Bench for lb_frame_sequencer with a 4x3 frame and a 4-cycle behavioural
// line buffer. Expected forwarded pixels and centre tags are queued when the
// stimulus is driven and popped as the DUT produces them.
module tb_lb_frame_sequencer;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cam_vsync;
    logic          cam_de;
    logic [DW-1:0] cam_data;
    logic          lb_vsync;
    logic          lb_valid;
    logic [DW-1:0] lb_data;
    logic          window_valid;
    logic          cen_valid;
    logic [9:0]    cen_x;
    logic [9:0]    cen_y;
    logic          busy;
    logic          frame_done;
    logic          err;

    lb_frame_sequencer #(
        .H_PIXEL    (H),
        .V_PIXEL    (V),
        .DATA_WIDTH (DW),
        .FLUSH_VALUE(8'd0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cam_vsync   (cam_vsync),
        .cam_de      (cam_de),
        .cam_data    (cam_data),
        .lb_vsync    (lb_vsync),
        .lb_valid    (lb_valid),
        .lb_data     (lb_data),
        .window_valid(window_valid),
        .cen_valid   (cen_valid),
        .cen_x       (cen_x),
        .cen_y       (cen_y),
        .busy        (busy),
        .frame_done  (frame_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    // behavioural line buffer: one window per input beat, 4 cycles later
    logic [3:0] lbp;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lbp <= '0;
        else        lbp <= {lbp[2:0], lb_valid};
    end
    assign window_valid = lbp[3];

    int n_tests = 0;
    int n_fail  = 0;
    int exp_lb[$];
    int exp_cen[$];
    int beat_cnt, win_cnt, cen_cnt, fd_cnt;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (lb_valid) begin
                beat_cnt++;
                if (exp_lb.size() == 0) chk("lb_extra", 1, 0);
                else chk("lb_data", int'(lb_data), exp_lb.pop_front());
            end
            if (window_valid) win_cnt++;
            if (cen_valid) begin
                cen_cnt++;
                if (exp_cen.size() == 0) chk("cen_extra", 1, 0);
                else chk("cen_xy", int'(cen_x) * 1024 + int'(cen_y), exp_cen.pop_front());
            end
            if (frame_done) fd_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        beat_cnt = 0; win_cnt = 0; cen_cnt = 0; fd_cnt = 0;
    endtask

    task automatic push_cen();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H - 1; x++)
                exp_cen.push_back(x * 1024 + y);
    endtask

    task automatic vsync_edge();
        cam_vsync = 1'b1;
        tick();
        cam_vsync = 1'b0;
    endtask

    // n pixels from start; gap inserts an idle cycle after each pixel;
    // poke drives a stray pixel in the second flush cycle
    task automatic drive_pix(input int n, input int start, input bit gap, input bit poke);
        for (int i = 0; i < n; i++) begin
            cam_de   = 1'b1;
            cam_data = DW'(start + i);
            exp_lb.push_back(start + i);
            tick();
            cam_de = 1'b0;
            if (i == H * V - 1)
                for (int k = 0; k < H; k++) exp_lb.push_back(0);
            if (gap) tick();
        end
        if (poke) begin
            tick();
            cam_de   = 1'b1;
            cam_data = 8'd99;
            tick();
            cam_de   = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (busy && n < 80) begin
            tick();
            n++;
        end
        chk("timeout", int'(n < 80), 1);
        tick();
        tick();
    endtask

    task automatic check_frame(input string name, input int exp_err);
        chk({name, "_beats"}, beat_cnt, H * (V + 1));
        chk({name, "_wins"},  win_cnt,  H * (V + 1));
        chk({name, "_cens"},  cen_cnt,  (H - 1) * V);
        chk({name, "_done"},  fd_cnt,   1);
        chk({name, "_busy"},  int'(busy), 0);
        chk({name, "_err"},   int'(err), exp_err);
        chk({name, "_lbq"},   exp_lb.size(), 0);
        chk({name, "_cenq"},  exp_cen.size(), 0);
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_lb_vsync"},   int'(lb_vsync), 0);
        chk({name, "_lb_valid"},   int'(lb_valid), 0);
        chk({name, "_lb_data"},    int'(lb_data), 0);
        chk({name, "_cen_valid"},  int'(cen_valid), 0);
        chk({name, "_cen_x"},      int'(cen_x), 0);
        chk({name, "_cen_y"},      int'(cen_y), 0);
        chk({name, "_busy"},       int'(busy), 0);
        chk({name, "_frame_done"}, int'(frame_done), 0);
        chk({name, "_err"},        int'(err), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cam_vsync = 1'b0;
        cam_de    = 1'b0;
        cam_data  = '0;
        clear_counts();
        #1;
        check_reset_vals("rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // nominal frame
        clear_counts();
        push_cen();
        vsync_edge();
        chk("nom_busy_on", int'(busy), 1);
        drive_pix(H * V, 1, 1'b0, 1'b0);
        wait_done();
        check_frame("nom", 0);

        // gappy input
        clear_counts();
        push_cen();
        vsync_edge();
        drive_pix(H * V, 21, 1'b1, 1'b0);
        wait_done();
        check_frame("gap", 0);

        // stray pixel in the second flush cycle
        clear_counts();
        push_cen();
        vsync_edge();
        drive_pix(H * V, 41, 1'b0, 1'b1);
        wait_done();
        check_frame("poke", 1);

        // abort after 6 pixels, then a complete frame from the abort edge
        clear_counts();
        push_cen();
        vsync_edge();
        drive_pix(6, 61, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        exp_cen.delete();
        chk("abort_lbq", exp_lb.size(), 0);
        vsync_edge();
        chk("abort_err", int'(err), 1);
        chk("abort_busy", int'(busy), 1);
        clear_counts();
        push_cen();
        drive_pix(H * V, 81, 1'b0, 1'b0);
        wait_done();
        check_frame("abort", 1);

        // reset during flush
        clear_counts();
        push_cen();
        vsync_edge();
        drive_pix(H * V, 101, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        exp_lb.delete();
        exp_cen.delete();
        tick();
        rst_n = 1'b1;
        tick();
        clear_counts();
        for (int i = 0; i < 3; i++) begin
            cam_de   = 1'b1;
            cam_data = DW'(200 + i);
            tick();
        end
        cam_de = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("postrst_beats", beat_cnt, 0);
        chk("postrst_wins",  win_cnt, 0);
        chk("postrst_busy",  int'(busy), 0);
        chk("postrst_err",   int'(err), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
